// File: rtl/reg_scoreboard_if.sv
// Issue, writeback and decode-query signals of the register-write scoreboard.
// The pipeline drives the master side and the scoreboard implements the slave side.
interface reg_scoreboard_if #(
  parameter int NREG  = 32,
  parameter int TOT_W = 6
);
  localparam int RW = $clog2(NREG);

  logic            issue_valid;
  logic            issue_regwrite;
  logic [RW-1:0]   issue_rd;
  logic            issue_ready;
  logic            wb_valid;
  logic [RW-1:0]   wb_rd;
  logic [RW-1:0]   rs1i;
  logic [RW-1:0]   rs2i;
  logic            rs1_used;
  logic            rs2_used;
  logic            hazard;
  logic [NREG-1:0] busy_vec;
  logic [TOT_W-1:0] pending_cnt;
  logic            err;

  modport master (
    output issue_valid, issue_regwrite, issue_rd, wb_valid, wb_rd,
           rs1i, rs2i, rs1_used, rs2_used,
    input  issue_ready, hazard, busy_vec, pending_cnt, err
  );

  modport slave (
    input  issue_valid, issue_regwrite, issue_rd, wb_valid, wb_rd,
           rs1i, rs2i, rs1_used, rs2_used,
    output issue_ready, hazard, busy_vec, pending_cnt, err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Register-write scoreboard: per-register outstanding-write counters set at issue,
// cleared at writeback, and queried by decode for source-operand hazards.
module reg_scoreboard #(
  parameter int NREG  = 32,
  parameter int CNT_W = 2,
  parameter int TOT_W = 6
) (
  input logic clk,
  input logic rst,
  reg_scoreboard_if.slave sb
);
  localparam int RW = $clog2(NREG);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [TOT_W-1:0] TOT_MAX = '1;

  logic [CNT_W-1:0] count [NREG];
  logic [TOT_W-1:0] total;
  logic             err_q;

  logic ev_i;
  logic ev_w;
  logic wb_orphan;

  // count[0] is reset to zero and never written afterwards, so r0 reads as idle.
  always_comb begin
    sb.issue_ready = ~sb.issue_regwrite | (sb.issue_rd == '0) |
                     (count[sb.issue_rd] != CNT_MAX);
    ev_i      = sb.issue_valid & sb.issue_regwrite & sb.issue_ready & (sb.issue_rd != '0);
    ev_w      = sb.wb_valid & (sb.wb_rd != '0) & (count[sb.wb_rd] != '0);
    wb_orphan = sb.wb_valid & (sb.wb_rd != '0) & (count[sb.wb_rd] == '0);
  end

  always_comb begin
    sb.hazard = (sb.rs1_used & (sb.rs1i != '0) & (count[sb.rs1i] != '0)) |
                (sb.rs2_used & (sb.rs2i != '0) & (count[sb.rs2i] != '0));
  end

  always_comb begin
    sb.busy_vec = '0;
    for (int r = 1; r < NREG; r++) begin
      sb.busy_vec[r] = (count[r] != '0);
    end
  end

  assign sb.pending_cnt = total;
  assign sb.err         = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        count[r] <= '0;
      end
      total <= '0;
      err_q <= 1'b0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (ev_i && (sb.issue_rd == RW'(r)) && !(ev_w && (sb.wb_rd == RW'(r)))) begin
          count[r] <= count[r] + CNT_W'(1);
        end else if (ev_w && (sb.wb_rd == RW'(r)) && !(ev_i && (sb.issue_rd == RW'(r)))) begin
          count[r] <= count[r] - CNT_W'(1);
        end
      end
      if (ev_i && !ev_w && (total != TOT_MAX)) begin
        total <= total + TOT_W'(1);
      end else if (ev_w && !ev_i && (total != '0)) begin
        total <= total - TOT_W'(1);
      end
      if (wb_orphan) begin
        err_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench: the driver pushes expected outputs from a behavioural model,
// a separate monitor pops and compares them against the DUT every cycle.
module tb_reg_scoreboard;
  localparam int NREG  = 32;
  localparam int TOT_W = 6;

  logic clk;
  logic rst;

  reg_scoreboard_if #(.NREG(NREG), .TOT_W(TOT_W)) sbi ();

  reg_scoreboard #(.NREG(NREG), .CNT_W(2), .TOT_W(TOT_W)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sbi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ready;
    logic        hazard;
    logic [31:0] busy;
    logic [5:0]  pend;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // behavioural model state
  int   m_cnt [NREG];
  int   m_tot;
  bit   m_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
    m_tot = 0;
    m_err = 0;
  endtask

  task automatic step(input logic iv, input logic rw, input logic [4:0] ird,
                      input logic wv, input logic [4:0] wrd,
                      input logic [4:0] r1, input logic u1,
                      input logic [4:0] r2, input logic u2,
                      input logic rs);
    exp_t e;
    bit   evi, evw;
    int   ii, wi;
    @(negedge clk);
    rst                 = rs;
    sbi.issue_valid     = iv;
    sbi.issue_regwrite  = rw;
    sbi.issue_rd        = ird;
    sbi.wb_valid        = wv;
    sbi.wb_rd           = wrd;
    sbi.rs1i            = r1;
    sbi.rs1_used        = u1;
    sbi.rs2i            = r2;
    sbi.rs2_used        = u2;
    ii = int'(ird);
    wi = int'(wrd);
    e.ready  = !rw || (ii == 0) || (m_cnt[ii] < 3);
    e.hazard = (u1 && r1 != 0 && m_cnt[int'(r1)] > 0) || (u2 && r2 != 0 && m_cnt[int'(r2)] > 0);
    e.busy   = '0;
    for (int r = 1; r < NREG; r++) e.busy[r] = (m_cnt[r] > 0);
    e.pend   = 6'(m_tot);
    e.err    = m_err;
    exp_q.push_back(e);
    if (rs) begin
      model_reset();
    end else begin
      evi = iv && rw && e.ready && (ii != 0);
      evw = wv && (wi != 0) && (m_cnt[wi] > 0);
      if (wv && wi != 0 && m_cnt[wi] == 0) m_err = 1;
      if (evi) m_cnt[ii] = m_cnt[ii] + 1;
      if (evw) m_cnt[wi] = m_cnt[wi] - 1;
      m_tot = m_tot + int'(evi) - int'(evw);
      if (m_tot > 63) m_tot = 63;
      if (m_tot < 0)  m_tot = 0;
    end
  endtask

  task automatic idle(input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2);
    step(0, 0, 0, 0, 0, r1, u1, r2, u2, 0);
  endtask

  task automatic iss(input logic [4:0] rd);
    step(1, 1, rd, 0, 0, rd, 1, 0, 0, 0);
  endtask

  task automatic wb(input logic [4:0] rd);
    step(0, 0, 0, 1, rd, rd, 1, 0, 0, 0);
  endtask

  // monitor: compare once per cycle, mid-low-phase, after the driver has settled
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("issue_ready", 64'(sbi.issue_ready), 64'(e.ready));
        chk("hazard",      64'(sbi.hazard),      64'(e.hazard));
        chk("busy_vec",    64'(sbi.busy_vec),    64'(e.busy));
        chk("pending_cnt", 64'(sbi.pending_cnt), 64'(e.pend));
        chk("err",         64'(sbi.err),         64'(e.err));
      end
    end
  end

  initial begin
    int wait_cyc;
    rst = 1'b1;
    sbi.issue_valid = 0; sbi.issue_regwrite = 0; sbi.issue_rd = 0;
    sbi.wb_valid = 0; sbi.wb_rd = 0;
    sbi.rs1i = 0; sbi.rs2i = 0; sbi.rs1_used = 0; sbi.rs2_used = 0;
    model_reset();
    @(negedge clk);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(0, 0, 0, 0);

    // single issue, hazard held through the writeback cycle
    iss(5);
    idle(5, 1, 0, 0);
    step(0, 0, 0, 1, 5, 5, 1, 0, 0, 0);
    idle(5, 1, 5, 1);

    // r0 is never tracked
    step(1, 1, 0, 1, 0, 0, 1, 0, 1, 0);
    idle(0, 1, 0, 1);

    // saturation on r7 and a dropped fourth issue
    iss(7); iss(7); iss(7);
    iss(7);
    idle(7, 1, 0, 0);
    wb(7);
    step(1, 1, 7, 0, 0, 0, 0, 7, 1, 0);
    wb(7); wb(7); wb(7);
    idle(7, 1, 7, 1);

    // same-cycle issue and writeback
    iss(9);
    step(1, 1, 9, 1, 9, 9, 1, 0, 0, 0);
    iss(4);
    step(1, 1, 3, 1, 4, 3, 1, 4, 1, 0);
    idle(3, 1, 4, 1);
    wb(9); wb(3);
    idle(9, 1, 3, 1);

    // orphan writeback sets sticky err
    wb(12);
    idle(12, 1, 0, 0);
    idle(0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(0, 0, 0, 0);

    // reset clears outstanding writes
    iss(2); iss(3);
    step(1, 1, 6, 1, 2, 2, 1, 3, 1, 1);
    idle(2, 1, 3, 1);

    // randomized traffic on a small register window to provoke collisions
    for (int n = 0; n < 600; n++) begin
      logic [4:0] ird, wrd, r1, r2;
      ird = 5'($urandom_range(0, 7));
      wrd = 5'($urandom_range(0, 7));
      r1  = 5'($urandom_range(0, 9));
      r2  = 5'($urandom_range(0, 9));
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0), ird,
           1'($urandom_range(0, 2) == 0), wrd,
           r1, 1'($urandom), r2, 1'($urandom),
           1'($urandom_range(0, 79) == 0));
    end
    idle(0, 0, 0, 0);

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Register-write scoreboard for the in-order RISC-V pipeline; the writer-side companion to decode-stage hazard detection.
- Issue records each regwrite instruction's destination register as pending; writeback retires it.
- Decode queries the two source registers and receives a registered-state stall request.
- Supports multiple outstanding writes per register, e.g. long-latency load/mul/div behind short ops.

Parameters:
- NREG, 32, number of architectural registers; index 0 is hardwired zero.
- CNT_W, 2, width of per-register outstanding-write counter; max count = 2^CNT_W - 1.
- TOT_W, 6, width of the total-outstanding counter.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- issue_valid  in  1  instruction leaving decode this cycle
- issue_regwrite  in  1  issuing instruction writes rd
- issue_rd  in  5  destination register of issuing instruction
- issue_ready  out  1  scoreboard can accept a write to issue_rd this cycle
- wb_valid  in  1  writeback retiring a register write this cycle
- wb_rd  in  5  register being written back
- rs1i  in  5  decode source register 1
- rs2i  in  5  decode source register 2
- rs1_used  in  1  instruction reads rs1
- rs2_used  in  1  instruction reads rs2
- hazard  out  1  a used source has an outstanding write; stall decode
- busy_vec  out  NREG  bit r = count[r] != 0; bit 0 always 0
- pending_cnt  out  TOT_W  total outstanding writes
- err  out  1  sticky: writeback to a register with count 0

Behaviour:
- State: count[r] (CNT_W bits) for r = 1..NREG-1; total counter; err flag.
- Reset (rst=1 at clk edge): all counts 0, pending_cnt=0, err=0. Reset overrides any same-cycle issue or wb, including mid-operation.
- Issue event: ev_i = issue_valid & issue_regwrite & issue_ready & (issue_rd != 0).
- issue_ready = (count[issue_rd] != max) | (issue_rd == 0) | ~issue_regwrite. Combinational from state.
- An issue_valid asserted while issue_ready=0 is dropped: no state change. Upstream must hold the instruction.
- Writeback event: ev_w = wb_valid & (wb_rd != 0) & (count[wb_rd] != 0).
- wb_valid with wb_rd != 0 and count 0: sets err (sticky until reset); counts unchanged.
- wb_valid with wb_rd = 0: ignored, no err.
- Count update, next edge:
  - ev_i only: count[issue_rd]+1.
  - ev_w only: count[wb_rd]-1.
  - Both on the same register: count unchanged.
  - Both on different registers: both updated.
- Counters never wrap. Saturation is prevented by issue_ready; underflow is prevented by the ev_w guard.
- pending_cnt: +1 on ev_i, -1 on ev_w, net 0 when both occur. Max in-flight sum must fit TOT_W by construction; on overflow, saturate.
- hazard = (rs1_used & rs1i != 0 & count[rs1i] != 0) | (rs2_used & rs2i != 0 & count[rs2i] != 0).
  - Combinational from registered counts only; zero-cycle latency from query.
  - A same-cycle wb does NOT clear hazard; the stall releases the cycle after the final writeback.
  - A same-cycle issue does NOT raise hazard; it is visible the next cycle.
- busy_vec and pending_cnt reflect registered state only.
- No internal state machine beyond the counters; no handshake latency other than one cycle from event to state.

Test Plan:
- Reset, then issue rd=5 -> next cycle busy_vec[5]=1, pending_cnt=1; query rs1i=5, rs1_used=1 gives hazard=1. wb rd=5 -> hazard stays 1 that cycle, then 0 next cycle, pending_cnt=0.
- Issue rd=0 with regwrite=1, and wb rd=0 -> no state change, hazard=0 for rs1i=0, err=0.
- Issue rd=7 three times -> count 3, issue_ready=0 for issue_rd=7. A fourth issue is dropped, pending_cnt stays 3. One wb rd=7 -> issue_ready=1 next cycle, and the register stays busy until two more wbs.
- Same cycle: issue rd=9 and wb rd=9 with count[9]=1 -> count stays 1, busy remains. Same cycle: issue rd=3 and wb rd=4 -> busy_vec[3]=1, busy_vec[4]=0.
- wb rd=12 while count[12]=0 -> err=1 and stays 1 across later cycles; counts unchanged; rst -> err=0.
- Issue rd=2, rd=3, then assert rst -> next cycle all counts 0, busy_vec=0, pending_cnt=0, hazard=0 for rs1i=2 and rs2i=3.
